// File: rtl/ob_sched_if.sv
// Bundle of the order-book scheduler's ingress, table-head, reject and
// response signals.
//   master : scheduler side (drives strobes, response and statistics)
//   slave  : datapath side (ingress queue, bid/ask tables, egress queue)
interface ob_sched_if #(
  parameter int unsigned UID_W   = 32,
  parameter int unsigned QTY_W   = 16,
  parameter int unsigned PRICE_W = 16
);
  // ingress queue pop side
  logic               ingress_vld;
  logic [1:0]         ingress_op;
  logic [UID_W-1:0]   ingress_uid;
  logic               ingress_consume;

  // bid / ask table heads
  logic               bid_head_vld_r;
  logic [UID_W-1:0]   bid_head_uid;
  logic [QTY_W-1:0]   bid_head_qty;
  logic [PRICE_W-1:0] bid_head_price;
  logic               bid_head_pop;
  logic               bid_head_upt;
  logic               ask_head_vld_r;
  logic [UID_W-1:0]   ask_head_uid;
  logic [QTY_W-1:0]   ask_head_qty;
  logic [PRICE_W-1:0] ask_head_price;
  logic               ask_head_pop;
  logic               ask_head_upt;
  logic [QTY_W-1:0]   head_upt_qty;

  // table reject queues
  logic               bid_reject_vld_r;
  logic [UID_W-1:0]   bid_reject_uid;
  logic               bid_reject_pop;
  logic               ask_reject_vld_r;
  logic [UID_W-1:0]   ask_reject_uid;
  logic               ask_reject_pop;

  // egress response queue push side
  logic               rsp_full;
  logic               rsp_push;
  logic [1:0]         rsp_type;
  logic [UID_W-1:0]   rsp_uid_a;
  logic [UID_W-1:0]   rsp_uid_b;
  logic [QTY_W-1:0]   rsp_qty;
  logic [PRICE_W-1:0] rsp_price;

  // statistics
  logic [31:0]        stat_trades;
  logic [31:0]        stat_cmds;

  modport master (
    input  ingress_vld, ingress_op, ingress_uid,
    output ingress_consume,
    input  bid_head_vld_r, bid_head_uid, bid_head_qty, bid_head_price,
    input  ask_head_vld_r, ask_head_uid, ask_head_qty, ask_head_price,
    output bid_head_pop, bid_head_upt, ask_head_pop, ask_head_upt, head_upt_qty,
    input  bid_reject_vld_r, bid_reject_uid, ask_reject_vld_r, ask_reject_uid,
    output bid_reject_pop, ask_reject_pop,
    input  rsp_full,
    output rsp_push, rsp_type, rsp_uid_a, rsp_uid_b, rsp_qty, rsp_price,
    output stat_trades, stat_cmds
  );

  modport slave (
    output ingress_vld, ingress_op, ingress_uid,
    input  ingress_consume,
    output bid_head_vld_r, bid_head_uid, bid_head_qty, bid_head_price,
    output ask_head_vld_r, ask_head_uid, ask_head_qty, ask_head_price,
    input  bid_head_pop, bid_head_upt, ask_head_pop, ask_head_upt, head_upt_qty,
    output bid_reject_vld_r, bid_reject_uid, ask_reject_vld_r, ask_reject_uid,
    input  bid_reject_pop, ask_reject_pop,
    output rsp_full,
    input  rsp_push, rsp_type, rsp_uid_a, rsp_uid_b, rsp_qty, rsp_price,
    input  stat_trades, stat_cmds
  );
endinterface

// File: rtl/ob_sched.sv
// Order-book sequencing controller. Each DECIDE slot performs at most one
// action, in priority order: drain a table reject, execute a bid/ask cross,
// or consume one ingress command. Trades and installs are followed by
// SETTLE_CYC dead cycles so the tables' heads can settle before re-sampling.
// Ports:
//   clk  : clock
//   rst  : asynchronous, active-low reset
//   bus  : ob_sched_if.master (ingress pop, table head/reject strobes,
//          response push, statistics)
// Optional: define OB_SCHED_STATS_EN to build the trade/command counters;
// otherwise stat_trades/stat_cmds are tied to 0.
module ob_sched #(
  parameter int unsigned UID_W      = 32,
  parameter int unsigned QTY_W      = 16,
  parameter int unsigned PRICE_W    = 16,
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic       clk,
  input  logic       rst,
  ob_sched_if.master bus
);
  localparam int unsigned CNT_W = 3;
  localparam logic [1:0] RSP_TRADE  = 2'd0;
  localparam logic [1:0] RSP_REJECT = 2'd1;
  localparam logic [1:0] RSP_BADOP  = 2'd2;

  typedef enum logic {ST_DECIDE, ST_SETTLE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   settle_cnt, settle_cnt_nxt;
  logic               rr, rr_nxt;          // 0: bid next on a reject tie, 1: ask
  logic               cross_pend;
  logic [QTY_W-1:0]   trade_qty;
  logic [PRICE_W-1:0] trade_price;
  logic [UID_W-1:0]   rej_uid;
  logic               rej_ask;
  logic               trade_fire;
  logic               cons_fire;

  // Cross detection and trade terms.
  assign cross_pend  = bus.bid_head_vld_r && bus.ask_head_vld_r &&
                       (bus.bid_head_price >= bus.ask_head_price);
  assign trade_qty   = (bus.bid_head_qty <= bus.ask_head_qty) ? bus.bid_head_qty
                                                              : bus.ask_head_qty;
  assign trade_price = bus.ask_head_price;

  // Reject arbitration: round-robin only when both sides are pending.
  assign rej_ask = bus.ask_reject_vld_r && (!bus.bid_reject_vld_r || rr);
  assign rej_uid = rej_ask ? bus.ask_reject_uid : bus.bid_reject_uid;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_DECIDE;
      settle_cnt <= '0;
      rr         <= 1'b0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_cnt_nxt;
      rr         <= rr_nxt;
    end
  end

  // Next-state and strobe decode; strobes only fire in DECIDE out of reset.
  always_comb begin
    state_nxt           = state;
    settle_cnt_nxt      = settle_cnt;
    rr_nxt              = rr;
    trade_fire          = 1'b0;
    cons_fire           = 1'b0;
    bus.ingress_consume = 1'b0;
    bus.bid_head_pop    = 1'b0;
    bus.bid_head_upt    = 1'b0;
    bus.ask_head_pop    = 1'b0;
    bus.ask_head_upt    = 1'b0;
    bus.head_upt_qty    = '0;
    bus.bid_reject_pop  = 1'b0;
    bus.ask_reject_pop  = 1'b0;
    bus.rsp_push        = 1'b0;
    bus.rsp_type        = RSP_TRADE;
    bus.rsp_uid_a       = '0;
    bus.rsp_uid_b       = '0;
    bus.rsp_qty         = '0;
    bus.rsp_price       = '0;

    unique case (state)
      ST_DECIDE: begin
        if (rst) begin
          if ((bus.bid_reject_vld_r || bus.ask_reject_vld_r) && !bus.rsp_full) begin
            bus.rsp_push       = 1'b1;
            bus.rsp_type       = RSP_REJECT;
            bus.rsp_uid_a      = rej_uid;
            bus.ask_reject_pop = rej_ask;
            bus.bid_reject_pop = !rej_ask;
            if (bus.bid_reject_vld_r && bus.ask_reject_vld_r) rr_nxt = !rr;
          end else if (cross_pend) begin
            // A pending cross blocks ingress even while the egress is full.
            if (!bus.rsp_full) begin
              trade_fire       = 1'b1;
              bus.rsp_push     = 1'b1;
              bus.rsp_type     = RSP_TRADE;
              bus.rsp_uid_a    = bus.bid_head_uid;
              bus.rsp_uid_b    = bus.ask_head_uid;
              bus.rsp_qty      = trade_qty;
              bus.rsp_price    = trade_price;
              bus.bid_head_pop = (bus.bid_head_qty == trade_qty);
              bus.ask_head_pop = (bus.ask_head_qty == trade_qty);
              if (bus.bid_head_qty != trade_qty) begin
                bus.bid_head_upt = 1'b1;
                bus.head_upt_qty = QTY_W'(bus.bid_head_qty - trade_qty);
              end else if (bus.ask_head_qty != trade_qty) begin
                bus.ask_head_upt = 1'b1;
                bus.head_upt_qty = QTY_W'(bus.ask_head_qty - trade_qty);
              end
              state_nxt      = ST_SETTLE;
              settle_cnt_nxt = CNT_W'(SETTLE_CYC - 1);
            end
          end else if (bus.ingress_vld) begin
            if (!bus.ingress_op[1]) begin
              // BUY/SELL install needs no response slot.
              cons_fire           = 1'b1;
              bus.ingress_consume = 1'b1;
              state_nxt           = ST_SETTLE;
              settle_cnt_nxt      = CNT_W'(SETTLE_CYC - 1);
            end else if (!bus.rsp_full) begin
              cons_fire           = 1'b1;
              bus.ingress_consume = 1'b1;
              bus.rsp_push        = 1'b1;
              bus.rsp_type        = RSP_BADOP;
              bus.rsp_uid_a       = bus.ingress_uid;
            end
          end
        end
      end
      ST_SETTLE: begin
        if (settle_cnt == '0) state_nxt = ST_DECIDE;
        else settle_cnt_nxt = CNT_W'(settle_cnt - 1'b1);
      end
      default: state_nxt = ST_DECIDE;
    endcase
  end

`ifdef OB_SCHED_STATS_EN
  logic [31:0] stat_trades_q, stat_cmds_q;

  // Free-running wrap-around event counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_trades_q <= '0;
      stat_cmds_q   <= '0;
    end else begin
      if (trade_fire) stat_trades_q <= 32'(stat_trades_q + 32'd1);
      if (cons_fire)  stat_cmds_q   <= 32'(stat_cmds_q + 32'd1);
    end
  end

  assign bus.stat_trades = stat_trades_q;
  assign bus.stat_cmds   = stat_cmds_q;
`else
  assign bus.stat_trades = '0;
  assign bus.stat_cmds   = '0;
`endif

  // Table heads never carry a zero quantity.
  a_bid_qty_nz: assert property (@(posedge clk) disable iff (!rst)
    bus.bid_head_vld_r |-> (bus.bid_head_qty != '0));
  a_ask_qty_nz: assert property (@(posedge clk) disable iff (!rst)
    bus.ask_head_vld_r |-> (bus.ask_head_qty != '0));

endmodule

// File: tb/tb_ob_sched.sv
// Directed testbench for ob_sched (SETTLE_CYC = 1): rejects with round-robin,
// partial and equal crosses, egress-full stalls, bad opcodes, async reset.
module tb_ob_sched;
  localparam int unsigned UID_W   = 32;
  localparam int unsigned QTY_W   = 16;
  localparam int unsigned PRICE_W = 16;
  localparam int unsigned VEC_W   = 122;

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;

  ob_sched_if #(.UID_W(UID_W), .QTY_W(QTY_W), .PRICE_W(PRICE_W)) bif ();

  ob_sched #(
    .UID_W(UID_W), .QTY_W(QTY_W), .PRICE_W(PRICE_W), .SETTLE_CYC(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Snapshot of every strobe/response output.
  function automatic logic [VEC_W-1:0] obs();
    return {bif.rsp_push, bif.rsp_type, bif.rsp_uid_a, bif.rsp_uid_b,
            bif.rsp_qty, bif.rsp_price, bif.bid_head_pop, bif.ask_head_pop,
            bif.bid_head_upt, bif.ask_head_upt, bif.head_upt_qty,
            bif.ingress_consume, bif.bid_reject_pop, bif.ask_reject_pop};
  endfunction

  // Expected snapshot, same field order as obs().
  function automatic logic [VEC_W-1:0] ev(
    input int unsigned push, typ, ua, ub, q, p, bp, ap, bu, au, uq, cons, brp, arp);
    return {1'(push), 2'(typ), 32'(ua), 32'(ub), 16'(q), 16'(p), 1'(bp), 1'(ap),
            1'(bu), 1'(au), 16'(uq), 1'(cons), 1'(brp), 1'(arp)};
  endfunction

  task automatic chk(input string tag, input logic [VEC_W-1:0] o, input logic [VEC_W-1:0] e);
    n_total++;
    assert (o === e) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bif.ingress_vld      = 1'b0;
    bif.ingress_op       = 2'd0;
    bif.ingress_uid      = '0;
    bif.bid_head_vld_r   = 1'b0;
    bif.bid_head_uid     = '0;
    bif.bid_head_qty     = '0;
    bif.bid_head_price   = '0;
    bif.ask_head_vld_r   = 1'b0;
    bif.ask_head_uid     = '0;
    bif.ask_head_qty     = '0;
    bif.ask_head_price   = '0;
    bif.bid_reject_vld_r = 1'b0;
    bif.bid_reject_uid   = '0;
    bif.ask_reject_vld_r = 1'b0;
    bif.ask_reject_uid   = '0;
    bif.rsp_full         = 1'b0;
  endtask

  task automatic set_bid(input int unsigned uid, qty, price);
    bif.bid_head_vld_r = 1'b1;
    bif.bid_head_uid   = 32'(uid);
    bif.bid_head_qty   = 16'(qty);
    bif.bid_head_price = 16'(price);
  endtask

  task automatic set_ask(input int unsigned uid, qty, price);
    bif.ask_head_vld_r = 1'b1;
    bif.ask_head_uid   = 32'(uid);
    bif.ask_head_qty   = 16'(qty);
    bif.ask_head_price = 16'(price);
  endtask

  task automatic chk_stats(input string tag, input int unsigned trades, cmds);
    chk({tag, "_trades"}, VEC_W'(bif.stat_trades), VEC_W'(trades));
    chk({tag, "_cmds"}, VEC_W'(bif.stat_cmds), VEC_W'(cmds));
  endtask

  logic [VEC_W-1:0] idle;

  initial begin
    n_total = 0;
    n_pass  = 0;
    idle    = ev(0,0,0,0,0,0,0,0,0,0,0,0,0,0);

    // Reset held: pending work must not produce strobes.
    rst = 1'b0;
    clr();
    bif.bid_reject_vld_r = 1'b1;
    bif.bid_reject_uid   = 32'd7;
    set_bid(1, 10, 100);
    set_ask(2, 4, 95);
    #2;
    chk("rst_idle", obs(), idle);
    chk_stats("rst", 0, 0);

    // Rejects: tie goes bid first after reset, then alternates.
    cyc();
    rst = 1'b1;
    clr();
    bif.bid_reject_vld_r = 1'b1; bif.bid_reject_uid = 32'd7;
    bif.ask_reject_vld_r = 1'b1; bif.ask_reject_uid = 32'd8;
    #1 chk("rej7", obs(), ev(1,1,7,0,0,0,0,0,0,0,0,0,1,0));
    cyc();
    bif.bid_reject_uid = 32'd9;
    #1 chk("rej8", obs(), ev(1,1,8,0,0,0,0,0,0,0,0,0,0,1));
    cyc();
    bif.ask_reject_uid = 32'd10;
    #1 chk("rej9_rr_bid", obs(), ev(1,1,9,0,0,0,0,0,0,0,0,0,1,0));
    cyc();
    bif.bid_reject_vld_r = 1'b0;
    #1 chk("rej10_single", obs(), ev(1,1,10,0,0,0,0,0,0,0,0,0,0,1));
    cyc();
    bif.bid_reject_vld_r = 1'b1; bif.bid_reject_uid = 32'd11;
    bif.ask_reject_uid = 32'd12;
    #1 chk("rej12_rr_hold", obs(), ev(1,1,12,0,0,0,0,0,0,0,0,0,0,1));
    cyc();
    bif.rsp_full = 1'b1;
    #1 chk("rej_full", obs(), idle);

    // Partial cross: ask fully filled, bid rewritten to 6.
    cyc();
    clr();
    set_bid(1, 10, 100);
    set_ask(2, 4, 95);
    #1 chk("trade_partial", obs(), ev(1,0,1,2,4,95,0,1,1,0,6,0,0,0));
    cyc();
    #1 chk("settle1", obs(), idle);
    // Equal quantity at equal price: both pop.
    cyc();
    set_bid(1, 6, 100);
    set_ask(3, 6, 100);
    #1 chk("trade_equal", obs(), ev(1,0,1,3,6,100,1,1,0,0,0,0,0,0));
    cyc();
    #1 chk("settle2", obs(), idle);

    // Egress full: crossed book blocks the BUY; trade goes first on release.
    cyc();
    clr();
    set_bid(4, 3, 50);
    set_ask(5, 7, 40);
    bif.ingress_vld = 1'b1; bif.ingress_op = 2'd0; bif.ingress_uid = 32'h20;
    bif.rsp_full = 1'b1;
    #1 chk("full_blk", obs(), idle);
    cyc();
    #1 chk("full_blk2", obs(), idle);
    cyc();
    bif.rsp_full = 1'b0;
    #1 chk("trade_after_full", obs(), ev(1,0,4,5,3,40,1,0,0,1,4,0,0,0));
    cyc();
    bif.bid_head_vld_r = 1'b0;
    bif.ask_head_qty   = 16'd4;
    #1 chk("settle3", obs(), idle);
    cyc();
    #1 chk("buy_consume", obs(), ev(0,0,0,0,0,0,0,0,0,0,0,1,0,0));
    cyc();
    bif.ingress_vld = 1'b0;
    #1 chk("settle4", obs(), idle);

    // Invalid opcodes: BADOP needs room; SELL does not.
    cyc();
    bif.ingress_vld = 1'b1; bif.ingress_op = 2'd3; bif.ingress_uid = 32'h55;
    #1 chk("badop", obs(), ev(1,2,32'h55,0,0,0,0,0,0,0,0,1,0,0));
    cyc();
    bif.rsp_full = 1'b1;
    #1 chk("badop_full", obs(), idle);
    cyc();
    bif.ingress_op = 2'd2;
    #1 chk("badop2_full", obs(), idle);
    cyc();
    bif.ingress_op = 2'd1; bif.ingress_uid = 32'h66;
    #1 chk("sell_full", obs(), ev(0,0,0,0,0,0,0,0,0,0,0,1,0,0));
    cyc();
    bif.ingress_vld = 1'b0;
    bif.rsp_full    = 1'b0;
    #1 chk("settle5", obs(), idle);
`ifdef OB_SCHED_STATS_EN
    chk_stats("mid", 3, 3);
`else
    chk_stats("mid", 0, 0);
`endif

    // Async reset in the trade cycle.
    cyc();
    clr();
    set_bid(6, 2, 10);
    set_ask(7, 2, 10);
    #1 chk("trade_rst", obs(), ev(1,0,6,7,2,10,1,1,0,0,0,0,0,0));
    #1 rst = 1'b0;
    #1 chk("rst_mid", obs(), idle);
    chk_stats("rst_mid", 0, 0);
    cyc();
    rst = 1'b1;
    clr();
    bif.bid_reject_vld_r = 1'b1; bif.bid_reject_uid = 32'd20;
    #1 chk("post_rst_rej", obs(), ev(1,1,20,0,0,0,0,0,0,0,0,0,1,0));
    chk_stats("post_rst", 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
